timer_load_slave: RTL
=====================

Name: timer_load_slave

Overview:
- Bus responder (slave) serving the timer masters' LOAD_VALUE reads on the shared 8-bit bus.
- Holds a bank of 8-bit load registers, written by the CPU/writer master and read by timer masters.
- Read data is registered and appears exactly one cycle after the address cycle. This matches the master sequence REQ -> GRANT (address driven) -> DELAY (data sampled).
- Sits behind the bus arbiter/mux. S_sel is the arbiter's "granted master targets this slave" strobe.

Parameters:
- BASE_ADDR, 8'h10, first bus address decoded by this slave.
- NUM_REGS, 8, number of load registers. Power of two, 2..16.
- RST_VAL, 8'h00, reset value of every load register.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- S_sel  input  1  bus access strobe: granted master's address phase is active this cycle.
- S_wr  input  1  1 = write, 0 = read; qualified by S_sel.
- S_address  input  8  bus address from the granted master.
- S_din  input  8  write data from the granted master.
- S_dout  output  8  registered read data to the bus (master's M_din).
- load_regs  output  8*NUM_REGS  flattened register bank; reg k is bits [8k+7:8k].
- wr_pulse  output  NUM_REGS  one-cycle pulse, bit k set the cycle after reg k is written.
- err  output  1  sticky access-error flag (mirror of STATUS[0]).

Behaviour:
- Reset (async, reset_n=0):
  - all load regs = RST_VAL.
  - S_dout=0, wr_pulse=0, err=0, read counter=0.
  - Reset mid-access aborts it: no write is committed and S_dout is 0 after release.
- Address map, offset = S_address - BASE_ADDR:
  - offsets 0..NUM_REGS-1: load regs, R/W.
  - offset NUM_REGS: STATUS, read-only except W1C. STATUS = {rd_cnt[6:0], err}.
  - any other address with S_sel=1 is an illegal access.
- Write (S_sel=1, S_wr=1), single cycle, committed on the same rising edge:
  - load reg: reg <= S_din, and wr_pulse[k]=1 in the next cycle only.
  - STATUS: S_din[0]=1 clears err; all other bits are ignored; rd_cnt is unaffected.
  - illegal: no register changes; err <= 1.
- Read (S_sel=1, S_wr=0):
  - S_dout is registered at that edge, so it is valid the whole following cycle (latency 1).
  - load reg: S_dout = reg value as of the address cycle, i.e. before any write in that same edge; rd_cnt increments.
  - STATUS: S_dout = STATUS value before update; rd_cnt does not increment.
  - illegal: S_dout = 8'h00; err <= 1.
- Idle (S_sel=0): S_dout <= 8'h00 on the next edge. Bus data is zero outside the read-data cycle (OR-mux friendly). No state changes.
- rd_cnt: 7-bit, wraps 127 -> 0 with no flag.
- Back-to-back accesses (S_sel high on consecutive cycles) are legal. Each cycle is an independent access; S_dout tracks each read with latency 1.
- An illegal access and a W1C of err cannot occur in the same cycle, because only one access happens per cycle.
- S_wr, S_address and S_din are don't-care when S_sel=0.
- No wait states. The slave never stalls the master.

Decomposition:
- Shared package holds:
  - default BASE_ADDR;
  - STATUS offset (= NUM_REGS);
  - STATUS bit positions (ERR_BIT=0, RDCNT_LSB=1);
  - bus width constant 8;
  - master state encodings (IDLE=3'b000 .. CNT_EN=3'b100), for bench use.
- No sub-module needed: a flat decoder plus register bank plus read mux (~150 lines). The bench instantiates timer_master alongside it.

Test Plan:
- Reset, then read offset 3 (S_address=8'h13) -> S_dout=8'h00 next cycle; rd_cnt=1; err=0.
- Write 8'hA5 to 8'h12, then read 8'h12 on the following cycle -> wr_pulse[2] high for exactly one cycle; S_dout=8'hA5 one cycle after the read address; load_regs[23:16]=8'hA5.
- Write 8'h3C to 8'h11 and read 8'h11 on back-to-back cycles -> read returns 8'h3C. A read in the same cycle as its own write is impossible, so also check the previous value is returned when the read comes first.
- Read 8'h30 (illegal) -> S_dout=8'h00; err=1. Read STATUS (8'h18) -> bit0=1. Write 8'h01 to 8'h18 -> err=0. A write to 8'h30 leaves all regs unchanged.
- 128 reads of reg 0 -> rd_cnt wraps to 0; STATUS read returns 8'h00 with err=0.
- Timer_master integration:
  - Preload 8'h5A at 8'h14. Assert read_req with LOAD_ADDRESS=8'h14 and the arbiter granting.
  - Required: LOAD_VALUE=8'h5A and CNT_EN pulses one cycle after the DELAY state.
  - Repeat with reset_n pulsed low during the GRANT cycle: LOAD_VALUE=0 and S_dout=0.

Source files
------------

// File: rtl/timer_load_slave_pkg.sv
// rtl/timer_load_slave_pkg.sv - shared constants and types for the timer load-register slave
package timer_load_slave_pkg;

  localparam int BUS_W = 8;
  localparam logic [BUS_W-1:0] DEFAULT_BASE_ADDR = 8'h10;

  localparam int ERR_BIT   = 0;
  localparam int RDCNT_LSB = 1;

  // Timer master state encodings, kept here so bus-side code can name them.
  localparam logic [2:0] MST_IDLE   = 3'b000;
  localparam logic [2:0] MST_REQ    = 3'b001;
  localparam logic [2:0] MST_GRANT  = 3'b010;
  localparam logic [2:0] MST_DELAY  = 3'b011;
  localparam logic [2:0] MST_CNT_EN = 3'b100;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_REG,
    ACC_STATUS,
    ACC_ILLEGAL
  } access_t;

  // STATUS sits directly after the last load register.
  function automatic logic [BUS_W-1:0] status_offset(input int num_regs);
    return BUS_W'(num_regs);
  endfunction

endpackage

// File: rtl/timer_load_slave_if.sv
// rtl/timer_load_slave_if.sv - shared 8-bit bus between a granted master and the load slave
interface timer_load_slave_if;
  import timer_load_slave_pkg::*;

  logic             S_sel;
  logic             S_wr;
  logic [BUS_W-1:0] S_address;
  logic [BUS_W-1:0] S_din;
  logic [BUS_W-1:0] S_dout;

  modport master (
    output S_sel,
    output S_wr,
    output S_address,
    output S_din,
    input  S_dout
  );

  modport slave (
    input  S_sel,
    input  S_wr,
    input  S_address,
    input  S_din,
    output S_dout
  );

endinterface

// File: rtl/timer_load_slave.sv
// rtl/timer_load_slave.sv - load-register bank with STATUS, registered read data, sticky error
module timer_load_slave
  import timer_load_slave_pkg::*;
#(
  parameter logic [BUS_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int               NUM_REGS  = 8,
  parameter logic [BUS_W-1:0] RST_VAL   = 8'h00
) (
  input  logic                      clk,
  input  logic                      reset_n,
  timer_load_slave_if.slave         bus,
  output logic [BUS_W*NUM_REGS-1:0] load_regs,
  output logic [NUM_REGS-1:0]       wr_pulse,
  output logic                      err
);

  localparam int               IDX_W      = $clog2(NUM_REGS);
  localparam logic [BUS_W-1:0] REG_LIMIT  = BUS_W'(NUM_REGS);
  localparam logic [BUS_W-1:0] STATUS_OFF = status_offset(NUM_REGS);

  logic [BUS_W-1:0] regs [NUM_REGS];
  logic [6:0]       rd_cnt;
  logic [BUS_W-1:0] offset;
  logic [IDX_W-1:0] idx;
  access_t          acc;
  logic [BUS_W-1:0] status_val;
  logic [BUS_W-1:0] rd_data;

  // Addresses below BASE_ADDR wrap to large offsets and fall into the illegal range.
  always_comb begin
    offset = bus.S_address - BASE_ADDR;
    idx    = offset[IDX_W-1:0];
    acc    = ACC_NONE;
    if (bus.S_sel) begin
      if (offset < REG_LIMIT)
        acc = ACC_REG;
      else if (offset == STATUS_OFF)
        acc = ACC_STATUS;
      else
        acc = ACC_ILLEGAL;
    end
  end

  always_comb begin
    status_val                   = '0;
    status_val[ERR_BIT]          = err;
    status_val[BUS_W-1:RDCNT_LSB] = rd_cnt;
  end

  always_comb begin
    rd_data = '0;
    case (acc)
      ACC_REG:    rd_data = regs[idx];
      ACC_STATUS: rd_data = status_val;
      default:    rd_data = '0;
    endcase
  end

  // Read data defaults to zero every cycle so the bus can be OR-muxed with other slaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REGS; k++)
        regs[k] <= RST_VAL;
      bus.S_dout <= '0;
      wr_pulse   <= '0;
      err        <= 1'b0;
      rd_cnt     <= '0;
    end else begin
      wr_pulse   <= '0;
      bus.S_dout <= '0;
      if (bus.S_wr) begin
        if (acc == ACC_REG) begin
          regs[idx]     <= bus.S_din;
          wr_pulse[idx] <= 1'b1;
        end
        if (acc == ACC_STATUS && bus.S_din[ERR_BIT])
          err <= 1'b0;
      end else begin
        bus.S_dout <= rd_data;
        if (acc == ACC_REG)
          rd_cnt <= rd_cnt + 7'd1;
      end
      if (acc == ACC_ILLEGAL)
        err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign load_regs[k*BUS_W +: BUS_W] = regs[k];
  end

endmodule
